// File: rtl/source_pool_arbiter.sv
// source_pool_arbiter: round-robin arbiter sharing one WQE source (credit) pool
// between NUM_REQ requesters. A grant deducts its length from the pool; credits
// come back through the release port, saturating at POOL_SIZE.
// Optional build macro: SOURCE_ARB_SKIP_EN
//   defined   - a request that does not fit is skipped and arbitration moves on
//   undefined - a request that does not fit stalls the arbiter until it fits
module source_pool_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned REQ_SEL_WIDTH     = 2,
    parameter int unsigned WQE_INDEX_WIDTH   = 10,
    parameter int unsigned WQE_SOURCE_LENGTH = 11,
    parameter int unsigned POOL_SIZE         = 1024
) (
    input  logic                                                    sys_clk,
    input  logic                                                    sys_rst_n,
    input  logic [NUM_REQ-1:0]                                      s_req_valid,
    input  logic [NUM_REQ*(WQE_INDEX_WIDTH+WQE_SOURCE_LENGTH)-1:0] s_req_id_len,
    output logic [NUM_REQ-1:0]                                      s_req_ready,
    input  logic                                                    s_release_valid,
    input  logic [WQE_SOURCE_LENGTH-1:0]                            s_release_len,
    output logic                                                    m_grant_valid,
    output logic [REQ_SEL_WIDTH-1:0]                                m_grant_req,
    output logic [WQE_INDEX_WIDTH+WQE_SOURCE_LENGTH-1:0]            m_grant_id_len,
    input  logic                                                    m_grant_ready,
    output logic [WQE_SOURCE_LENGTH-1:0]                            source_available,
    output logic                                                    release_overflow
);

    localparam int unsigned IdLenW = WQE_INDEX_WIDTH + WQE_SOURCE_LENGTH;
    localparam int unsigned LenW   = WQE_SOURCE_LENGTH;
    localparam logic [LenW:0] PoolExt = (LenW+1)'(POOL_SIZE);

    typedef enum logic [1:0] {StIdle, StArb, StGrant} state_e;

    state_e                   r_state;
    logic [REQ_SEL_WIDTH-1:0] r_rr;
    logic [REQ_SEL_WIDTH-1:0] r_sel;
    logic [IdLenW-1:0]        r_sel_id_len;
    logic [LenW-1:0]          r_avail;
    logic                     r_grant_valid;
    logic [REQ_SEL_WIDTH-1:0] r_grant_req;
    logic [IdLenW-1:0]        r_grant_id_len;
    logic [NUM_REQ-1:0]       r_req_ready;
    logic                     r_release_overflow;

    logic                     w_pick_found;
    logic [REQ_SEL_WIDTH-1:0] w_pick;
    logic [IdLenW-1:0]        w_pick_id_len;
    int unsigned              w_idx;
    logic [REQ_SEL_WIDTH-1:0] w_idx_sel;
    logic [LenW-1:0]          w_sel_len;
    logic                     w_fits;
    logic                     w_grant_now;
    logic [NUM_REQ-1:0]       w_sel_onehot;
    logic [LenW:0]            w_avail_sum;
    logic                     w_over;

    // Round-robin search: first valid requester after r_rr, wrapping around
    always_comb begin
        w_pick_found  = 1'b0;
        w_pick        = '0;
        w_pick_id_len = '0;
        w_idx         = 0;
        w_idx_sel     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_idx = 32'(r_rr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_idx_sel = REQ_SEL_WIDTH'(w_idx);
            if (!w_pick_found && s_req_valid[w_idx_sel]) begin
                w_pick_found  = 1'b1;
                w_pick        = w_idx_sel;
                w_pick_id_len = s_req_id_len[w_idx*IdLenW +: IdLenW];
            end
        end
    end

    // Fit check on the latched request and next pool value (deduct and release together)
    always_comb begin
        w_sel_len    = r_sel_id_len[IdLenW-1 -: LenW];
        w_fits       = (w_sel_len <= r_avail);
        w_grant_now  = (r_state == StArb) && s_req_valid[r_sel] && w_fits;
        w_sel_onehot = NUM_REQ'(1) << r_sel;
        // deduct never exceeds r_avail, so the extra bit only absorbs release overshoot
        w_avail_sum  = {1'b0, r_avail}
                     - {1'b0, (w_grant_now ? w_sel_len : {LenW{1'b0}})}
                     + {1'b0, (s_release_valid ? s_release_len : {LenW{1'b0}})};
        w_over       = (w_avail_sum > PoolExt);
    end

    // Credit pool register with saturation and overflow pulse
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_avail            <= PoolExt[LenW-1:0];
            r_release_overflow <= 1'b0;
        end else begin
            r_avail            <= w_over ? PoolExt[LenW-1:0] : w_avail_sum[LenW-1:0];
            r_release_overflow <= w_over;
        end
    end

    // Arbitration FSM with registered grant outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state        <= StIdle;
            r_rr           <= REQ_SEL_WIDTH'(NUM_REQ - 1);
            r_sel          <= '0;
            r_sel_id_len   <= '0;
            r_grant_valid  <= 1'b0;
            r_grant_req    <= '0;
            r_grant_id_len <= '0;
            r_req_ready    <= '0;
        end else begin
            r_req_ready <= '0;
            case (r_state)
                StIdle: begin
                    if (w_pick_found) begin
                        r_sel        <= w_pick;
                        r_sel_id_len <= w_pick_id_len;
                        r_state      <= StArb;
                    end
                end
                StArb: begin
                    if (!s_req_valid[r_sel]) begin
                        r_state <= StIdle;
                    end else if (w_fits) begin
                        r_grant_valid  <= 1'b1;
                        r_grant_req    <= r_sel;
                        r_grant_id_len <= r_sel_id_len;
                        r_req_ready    <= w_sel_onehot;
                        r_state        <= StGrant;
                    end else begin
`ifdef SOURCE_ARB_SKIP_EN
                        // move past the starved requester to avoid head-of-line blocking
                        r_rr    <= r_sel;
                        r_state <= StIdle;
`else
                        // hold until releases make room; strict fairness
                        r_state <= StArb;
`endif
                    end
                end
                StGrant: begin
                    if (m_grant_ready) begin
                        r_grant_valid <= 1'b0;
                        r_rr          <= r_sel;
                        r_state       <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign s_req_ready      = r_req_ready;
    assign m_grant_valid    = r_grant_valid;
    assign m_grant_req      = r_grant_req;
    assign m_grant_id_len   = r_grant_id_len;
    assign source_available = r_avail;
    assign release_overflow = r_release_overflow;

endmodule

// File: tb/tb_source_pool_arbiter.sv
// Bench for source_pool_arbiter: table of per-cycle vectors plus hand-written
// sequences for credit starvation and reset-in-grant.
module tb_source_pool_arbiter;

    localparam int IDW  = 10;
    localparam int LW   = 11;
    localparam int IDLW = IDW + LW;

    logic            sys_clk = 1'b0;
    logic            sys_rst_n;
    logic [3:0]      s_req_valid;
    logic [4*IDLW-1:0] s_req_id_len;
    logic [3:0]      s_req_ready;
    logic            s_release_valid;
    logic [LW-1:0]   s_release_len;
    logic            m_grant_valid;
    logic [1:0]      m_grant_req;
    logic [IDLW-1:0] m_grant_id_len;
    logic            m_grant_ready;
    logic [LW-1:0]   source_available;
    logic            release_overflow;

    int checks = 0;
    int errors = 0;

    source_pool_arbiter dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .s_req_valid     (s_req_valid),
        .s_req_id_len    (s_req_id_len),
        .s_req_ready     (s_req_ready),
        .s_release_valid (s_release_valid),
        .s_release_len   (s_release_len),
        .m_grant_valid   (m_grant_valid),
        .m_grant_req     (m_grant_req),
        .m_grant_id_len  (m_grant_id_len),
        .m_grant_ready   (m_grant_ready),
        .source_available(source_available),
        .release_overflow(release_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [10:0] len;
        logic        rel_v;
        logic [10:0] rel_len;
        logic        gready;
        logic        gv;
        logic [1:0]  greq;
        logic [3:0]  rdy;
        logic [10:0] av;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int rst, input int valid, input int len, input int rel_v,
                                input int rel_len, input int gready, input int gv,
                                input int greq, input int rdy, input int av, input int ovf);
        vec_t v;
        v.rst = 1'(rst);      v.valid = 4'(valid);    v.len = 11'(len);
        v.rel_v = 1'(rel_v);  v.rel_len = 11'(rel_len); v.gready = 1'(gready);
        v.gv = 1'(gv);        v.greq = 2'(greq);      v.rdy = 4'(rdy);
        v.av = 11'(av);       v.ovf = 1'(ovf);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_req(input int k, input int len);
        logic [IDLW-1:0] w;
        w = {11'(len), 10'(k + 4)};
        s_req_id_len[k*IDLW +: IDLW] = w;
    endtask

    task automatic clear_inputs();
        s_req_valid     = '0;
        s_req_id_len    = '0;
        s_release_valid = 1'b0;
        s_release_len   = '0;
        m_grant_ready   = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        sys_rst_n = 1'b0;
        #2;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // reset values
        sys_rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_gv",    0, int'(m_grant_valid), 0);
        check("rst_greq",  0, int'(m_grant_req), 0);
        check("rst_idlen", 0, int'(m_grant_id_len), 0);
        check("rst_ready", 0, int'(s_req_ready), 0);
        check("rst_avail", 0, int'(source_available), 1024);
        check("rst_ovf",   0, int'(release_overflow), 0);
        sys_rst_n = 1'b1;

        //                  rst valid len rv rl gr | gv greq rdy av ovf
        // single request: requester 1 len 100 id 5, hold then accept
        vecs.push_back(mk(1, 'b0010, 100, 0, 0, 0,  0, 0, 'b0000, 1024, 0));
        vecs.push_back(mk(0, 'b0010, 100, 0, 0, 0,  1, 1, 'b0010,  924, 0));
        vecs.push_back(mk(0, 'b0000, 100, 0, 0, 0,  1, 1, 'b0000,  924, 0));
        vecs.push_back(mk(0, 'b0000, 100, 0, 0, 1,  0, 0, 'b0000,  924, 0));
        // round robin, all requesting len 10
        vecs.push_back(mk(1, 'b1111, 10, 0, 0, 1,  0, 0, 'b0000, 1024, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  1, 0, 'b0001, 1014, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  0, 0, 'b0000, 1014, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  0, 0, 'b0000, 1014, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  1, 1, 'b0010, 1004, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  0, 0, 'b0000, 1004, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  0, 0, 'b0000, 1004, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  1, 2, 'b0100,  994, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  0, 0, 'b0000,  994, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  0, 0, 'b0000,  994, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  1, 3, 'b1000,  984, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  0, 0, 'b0000,  984, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  0, 0, 'b0000,  984, 0));
        vecs.push_back(mk(0, 'b1111, 10, 0, 0, 1,  1, 0, 'b0001,  974, 0));
        vecs.push_back(mk(0, 'b0000, 10, 0, 0, 1,  0, 0, 'b0000,  974, 0));
        // release overflow: avail 1000 + 100 saturates at 1024
        vecs.push_back(mk(1, 'b0001, 24, 0, 0, 1,  0, 0, 'b0000, 1024, 0));
        vecs.push_back(mk(0, 'b0001, 24, 0, 0, 1,  1, 0, 'b0001, 1000, 0));
        vecs.push_back(mk(0, 'b0000, 24, 0, 0, 1,  0, 0, 'b0000, 1000, 0));
        vecs.push_back(mk(0, 'b0000, 0, 1, 100, 1, 0, 0, 'b0000, 1024, 1));
        vecs.push_back(mk(0, 'b0000, 0, 0, 0, 1,   0, 0, 'b0000, 1024, 0));
        // simultaneous deduct 30 and release 40 at avail 500
        vecs.push_back(mk(1, 'b0001, 524, 0, 0, 1, 0, 0, 'b0000, 1024, 0));
        vecs.push_back(mk(0, 'b0001, 524, 0, 0, 1, 1, 0, 'b0001,  500, 0));
        vecs.push_back(mk(0, 'b0000, 524, 0, 0, 1, 0, 0, 'b0000,  500, 0));
        vecs.push_back(mk(0, 'b0001, 30, 0, 0, 0,  0, 0, 'b0000,  500, 0));
        vecs.push_back(mk(0, 'b0001, 30, 1, 40, 0, 1, 0, 'b0001,  510, 0));
        vecs.push_back(mk(0, 'b0000, 30, 0, 0, 1,  0, 0, 'b0000,  510, 0));
        // len 0 always fits, release of 0 is a no-op
        vecs.push_back(mk(0, 'b0010, 0, 0, 0, 1,   0, 0, 'b0000,  510, 0));
        vecs.push_back(mk(0, 'b0010, 0, 0, 0, 1,   1, 1, 'b0010,  510, 0));
        vecs.push_back(mk(0, 'b0000, 0, 0, 0, 1,   0, 0, 'b0000,  510, 0));
        vecs.push_back(mk(0, 'b0000, 0, 1, 0, 1,   0, 0, 'b0000,  510, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst) apply_reset();
            s_req_valid = vecs[i].valid;
            for (int k = 0; k < 4; k++) set_req(k, int'(vecs[i].len));
            s_release_valid = vecs[i].rel_v;
            s_release_len   = vecs[i].rel_len;
            m_grant_ready   = vecs[i].gready;
            step();
            check("grant_valid", i, int'(m_grant_valid), int'(vecs[i].gv));
            check("req_ready",   i, int'(s_req_ready), int'(vecs[i].rdy));
            check("avail",       i, int'(source_available), int'(vecs[i].av));
            check("overflow",    i, int'(release_overflow), int'(vecs[i].ovf));
            if (vecs[i].gv) begin
                check("grant_req", i, int'(m_grant_req), int'(vecs[i].greq));
                check("grant_idlen", i, int'(m_grant_id_len),
                      int'({vecs[i].len, 10'(vecs[i].greq + 2'd0) + 10'd4}));
            end
        end

        // starvation: avail 50, requester 0 wants 60, requester 1 wants 20
        apply_reset();
        set_req(3, 974);
        s_req_valid   = 4'b1000;
        step();
        step();
        check("starve_setup_gv",  100, int'(m_grant_valid), 1);
        check("starve_setup_req", 100, int'(m_grant_req), 3);
        check("starve_setup_av",  100, int'(source_available), 50);
        s_req_valid   = 4'b0000;
        m_grant_ready = 1'b1;
        step();
        check("starve_setup_done", 101, int'(m_grant_valid), 0);
        set_req(0, 60);
        set_req(1, 20);
        s_req_valid = 4'b0011;
`ifdef SOURCE_ARB_SKIP_EN
        for (int c = 0; c < 3; c++) begin
            step();
            check("skip_wait_gv", 110 + c, int'(m_grant_valid), 0);
        end
        step();
        check("skip_gv",    120, int'(m_grant_valid), 1);
        check("skip_req",   120, int'(m_grant_req), 1);
        check("skip_ready", 120, int'(s_req_ready), 'b0010);
        check("skip_av",    120, int'(source_available), 30);
`else
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall_wait_gv", 110 + c, int'(m_grant_valid), 0);
            check("stall_wait_av", 110 + c, int'(source_available), 50);
        end
        s_release_valid = 1'b1;
        s_release_len   = 11'd10;
        step();
        s_release_valid = 1'b0;
        s_release_len   = '0;
        check("stall_rel_gv", 119, int'(m_grant_valid), 0);
        check("stall_rel_av", 119, int'(source_available), 60);
        step();
        check("stall_gv",    120, int'(m_grant_valid), 1);
        check("stall_req",   120, int'(m_grant_req), 0);
        check("stall_ready", 120, int'(s_req_ready), 'b0001);
        check("stall_av",    120, int'(source_available), 0);
`endif

        // reset asserted while a grant is pending
        apply_reset();
        set_req(2, 5);
        s_req_valid   = 4'b0100;
        m_grant_ready = 1'b0;
        step();
        step();
        check("pend_gv",  130, int'(m_grant_valid), 1);
        check("pend_req", 130, int'(m_grant_req), 2);
        check("pend_av",  130, int'(source_available), 1019);
        sys_rst_n = 1'b0;
        #1;
        check("async_rst_gv", 131, int'(m_grant_valid), 0);
        check("async_rst_av", 131, int'(source_available), 1024);
        check("async_rst_req", 131, int'(m_grant_req), 0);
        #1;
        sys_rst_n = 1'b1;
        set_req(0, 5);
        s_req_valid = 4'b0101;
        step();
        step();
        check("post_rst_gv",    132, int'(m_grant_valid), 1);
        check("post_rst_req",   132, int'(m_grant_req), 0);
        check("post_rst_ready", 132, int'(s_req_ready), 'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
